// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared alarm-controller state encoding and time/tick constants
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int HRS_MAX      = 23;
  localparam int MIN_MAX      = 59;
  localparam int RING_TICKS   = 60;
  localparam int SNOOZE_TICKS = 300;
  localparam int MAX_SNOOZE   = 3;
  localparam int ALM_HRS_RST  = 6;

endpackage

// File: rtl/mod_updown.sv
// rtl/mod_updown.sv - modulo-N up/down field register; inc wins over dec, wraps both ways
module mod_updown #(
  parameter int N       = 24,
  parameter int W       = 5,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] TOP  = W'(N - 1);
  localparam logic [W-1:0] INIT = W'(RST_VAL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= INIT;
    end else if (en) begin
      if (inc) begin
        value <= (value == TOP) ? '0 : value + 1'b1;
      end else if (dec) begin
        value <= (value == '0) ? TOP : value - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - watch alarm FSM with field editing; ALARM_SNOOZE_EN adds the snooze state
module alarm_ctrl
  import watch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [4:0] hrs,
  input  logic [5:0] mins,
  input  logic [5:0] sec,
  input  logic       set_en,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       arm,
  input  logic       stop,
  input  logic       snooze,
  output logic [4:0] alm_hrs,
  output logic [5:0] alm_mins,
  output logic       armed,
  output logic       ring,
  output logic       fld
);

  localparam logic [5:0] RING_LAST = 6'(RING_TICKS - 1);

  alarm_state_t state_q, state_d;
  logic [5:0]   ring_cnt;
  logic         edit_ok;
  logic         match;
  logic         snooze_ok;

  // arm takes precedence over any edit in the same cycle
  assign edit_ok = (state_q == IDLE) && set_en && !arm;
  assign match   = tick && (hrs == alm_hrs) && (mins == alm_mins) && (sec == 6'd0);

  mod_updown #(.N(HRS_MAX + 1), .W(5), .RST_VAL(ALM_HRS_RST)) u_hrs (
    .clk   (clk),
    .rst   (rst),
    .en    (edit_ok && !fld),
    .inc   (inc),
    .dec   (dec),
    .value (alm_hrs)
  );

  mod_updown #(.N(MIN_MAX + 1), .W(6), .RST_VAL(0)) u_mins (
    .clk   (clk),
    .rst   (rst),
    .en    (edit_ok && fld),
    .inc   (inc),
    .dec   (dec),
    .value (alm_mins)
  );

`ifdef ALARM_SNOOZE_EN
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_TICKS - 1);
  logic [8:0] snz_cnt;
  logic [1:0] snz_used;

  assign snooze_ok = snooze && (snz_used != 2'(MAX_SNOOZE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snz_cnt  <= '0;
      snz_used <= '0;
    end else begin
      if (state_q != SNOOZE || state_d != SNOOZE) snz_cnt <= '0;
      else if (tick)                              snz_cnt <= snz_cnt + 9'd1;
      if (state_d == IDLE || state_d == ARMED)             snz_used <= '0;
      else if (state_q == RINGING && state_d == SNOOZE)    snz_used <= snz_used + 2'd1;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snooze_ok     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED: begin
        if (arm)        state_d = IDLE;
        else if (match) state_d = RINGING;
      end
      RINGING: begin
        if (arm)                                state_d = IDLE;
        else if (stop)                          state_d = ARMED;
        else if (snooze_ok)                     state_d = SNOOZE;
        else if (tick && ring_cnt == RING_LAST) state_d = ARMED;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (arm)                                 state_d = IDLE;
        else if (stop)                           state_d = ARMED;
        else if (tick && snz_cnt == SNOOZE_LAST) state_d = RINGING;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ring/armed are flopped from the next state so they stay free of input-to-output paths
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ring_cnt <= '0;
      fld      <= 1'b0;
      ring     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state_q <= state_d;
      ring    <= (state_d == RINGING);
      armed   <= (state_d != IDLE);
      if (edit_ok && sel) fld <= ~fld;
      if (state_q != RINGING || state_d != RINGING) ring_cnt <= '0;
      else if (tick)                                ring_cnt <= ring_cnt + 6'd1;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed and randomized bench for alarm_ctrl against a behavioural model
module tb_alarm_ctrl;

  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0;
  logic [4:0] hrs = '0;
  logic [5:0] mins = '0, sec = '0;
  logic       set_en = 1'b0, sel = 1'b0, inc = 1'b0, dec = 1'b0;
  logic       arm = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [4:0] alm_hrs;
  logic [5:0] alm_mins;
  logic       armed, ring, fld;

`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

  int checks = 0, errors = 0;
  int m_mode, m_ah, m_am, m_fld, m_rings, m_snz, m_used;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .hrs(hrs), .mins(mins), .sec(sec),
    .set_en(set_en), .sel(sel), .inc(inc), .dec(dec),
    .arm(arm), .stop(stop), .snooze(snooze),
    .alm_hrs(alm_hrs), .alm_mins(alm_mins), .armed(armed), .ring(ring), .fld(fld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_ah = 6; m_am = 0; m_fld = 0; m_rings = 0; m_snz = 0; m_used = 0;
  endtask

  // Alarm behaviour as rules: elapsed tick counts and modular time arithmetic
  task automatic model_step();
    int d;
    case (m_mode)
      M_IDLE: begin
        if (arm) begin
          m_mode = M_ARMED; m_used = 0;
        end else if (set_en) begin
          d = inc ? 1 : (dec ? -1 : 0);
          if (m_fld == 0) m_ah = (m_ah + 24 + d) % 24;
          else            m_am = (m_am + 60 + d) % 60;
          if (sel) m_fld = 1 - m_fld;
        end
      end
      M_ARMED: begin
        if (arm) m_mode = M_IDLE;
        else if (tick && hrs == m_ah && mins == m_am && sec == 0) begin
          m_mode = M_RING; m_rings = 0;
        end
      end
      M_RING: begin
        if (arm) begin
          m_mode = M_IDLE; m_used = 0;
        end else if (stop) begin
          m_mode = M_ARMED; m_used = 0;
        end else if (SNZ && snooze && m_used < 3) begin
          m_mode = M_SNOOZE; m_used++; m_snz = 0;
        end else if (tick) begin
          m_rings++;
          if (m_rings == 60) begin m_mode = M_ARMED; m_used = 0; end
        end
      end
      default: begin
        if (arm) begin
          m_mode = M_IDLE; m_used = 0;
        end else if (stop) begin
          m_mode = M_ARMED; m_used = 0;
        end else if (tick) begin
          m_snz++;
          if (m_snz == 300) begin m_mode = M_RING; m_rings = 0; end
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ring"},  32'(ring),     32'(m_mode == M_RING));
    check({tag, ".armed"}, 32'(armed),    32'(m_mode != M_IDLE));
    check({tag, ".hrs"},   32'(alm_hrs),  m_ah);
    check({tag, ".mins"},  32'(alm_mins), m_am);
    check({tag, ".fld"},   32'(fld),      m_fld);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic clr();
    set_en = 0; sel = 0; inc = 0; dec = 0; arm = 0; stop = 0; snooze = 0; tick = 0;
  endtask

  task automatic trigger();
    hrs = 5'd7; mins = 6'd30; sec = 6'd0; tick = 1;
    step("trigger");
    mins = 6'd31; tick = 0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1;
    #1;
    check({tag, ".ring"},  32'(ring),     0);
    check({tag, ".armed"}, 32'(armed),    0);
    check({tag, ".hrs"},   32'(alm_hrs),  6);
    check({tag, ".mins"},  32'(alm_mins), 0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    model_reset();
    #1 rst = 1;
    #11;
    check("rst.hrs", 32'(alm_hrs), 6);
    check("rst.mins", 32'(alm_mins), 0);
    check("rst.fld", 32'(fld), 0);
    check("rst.ring", 32'(ring), 0);
    check("rst.armed", 32'(armed), 0);
    rst = 0;

    set_en = 1; dec = 1;
    repeat (7) step("edit_dec");
    check("hrs_wrap_down", 32'(alm_hrs), 23);
    dec = 0; sel = 1; step("sel"); sel = 0;
    check("fld_mins", 32'(fld), 1);
    dec = 1; step("min_dec"); dec = 0;
    check("mins_wrap_down", 32'(alm_mins), 59);
    inc = 1; step("min_inc");
    check("mins_wrap_up", 32'(alm_mins), 0);

    inc = 0; sel = 1; step("sel_h"); sel = 0; inc = 1;
    repeat (8) step("set_h");
    inc = 0; sel = 1; step("sel_m"); sel = 0; inc = 1;
    repeat (30) step("set_m");
    clr();
    check("set_hrs", 32'(alm_hrs), 7);
    check("set_mins", 32'(alm_mins), 30);

    arm = 1; set_en = 1; inc = 1; step("arm_pri"); arm = 0;
    check("arm_pri.hrs", 32'(alm_hrs), 7);
    step("edit_in_armed"); clr();
    check("edit_ignored", 32'(alm_mins), 30);

    hrs = 5'd7; mins = 6'd30; sec = 6'd0; tick = 0;
    step("match_no_tick");
    check("no_tick_ring", 32'(ring), 0);
    trigger();
    check("trig_ring", 32'(ring), 1);

    mins = 6'd31; tick = 1;
    repeat (59) step("ringing");
    check("ring_59", 32'(ring), 1);
    step("timeout"); tick = 0;
    check("timeout_ring", 32'(ring), 0);
    check("timeout_armed", 32'(armed), 1);

    trigger();
    stop = 1; snooze = 1; step("stop_snz"); clr();
    check("stop_snz_ring", 32'(ring), 0);
    check("stop_snz_armed", 32'(armed), 1);
    trigger();
    arm = 1; stop = 1; step("arm_stop"); clr();
    check("arm_stop_armed", 32'(armed), 0);
    arm = 1; step("rearm"); arm = 0;

`ifdef ALARM_SNOOZE_EN
    trigger();
    for (int n = 0; n < 3; n++) begin
      snooze = 1; step("snooze"); snooze = 0;
      check("snooze_ring", 32'(ring), 0);
      tick = 1;
      repeat (299) step("snoozing");
      check("snooze_299", 32'(ring), 0);
      step("snooze_end"); tick = 0;
      check("snooze_ring_again", 32'(ring), 1);
    end
    snooze = 1; step("snooze4"); snooze = 0;
    check("snooze4_ignored", 32'(ring), 1);
    stop = 1; step("stop"); stop = 0;
    trigger();
    snooze = 1; step("snooze_pre_rst"); snooze = 0;
    tick = 1; repeat (20) step("snoozing"); tick = 0;
    async_reset("rst_snooze");
`else
    trigger();
    snooze = 1; step("snooze_off"); snooze = 0;
    check("snooze_off_ring", 32'(ring), 1);
    async_reset("rst_ringing");
`endif
    check_model("after_rst");

    repeat (4000) begin
      arm    = ($urandom_range(0, 99) < 3);
      stop   = ($urandom_range(0, 99) < 2);
      snooze = ($urandom_range(0, 99) < 8);
      set_en = ($urandom_range(0, 99) < 50);
      sel    = ($urandom_range(0, 99) < 20);
      inc    = ($urandom_range(0, 99) < 30);
      dec    = ($urandom_range(0, 99) < 30);
      tick   = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 1) == 0) begin
        hrs = 5'(m_ah); mins = 6'(m_am);
      end else begin
        hrs = 5'($urandom_range(0, 23)); mins = 6'($urandom_range(0, 59));
      end
      sec = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 59)) : 6'd0;
      step("rand");
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst, with rst asynchronous and active-high.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 tick  in  1  one-cycle strobe, high on the cycle the watch seconds counter advances.
REQ-005 hrs  in  5  current hour, 0..23; mins in 6, current minute, 0..59; sec in 6, current second, 0..59.
REQ-006 set_en  in  1  alarm edit enable; sel in 1, toggles the edit field; inc / dec in 1, adjust the selected field.
REQ-007 arm  in  1  toggle armed; stop in 1, silence the alarm; snooze in 1, request snooze.
REQ-008 alm_hrs  out  5  / alm_mins  out  6  programmed alarm time.
REQ-009 armed  out  1  high in ARMED, RINGING and SNOOZE; ring out 1, high only in RINGING; fld out 1, edit field (0=hours, 1=minutes).

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, ARMED, RINGING and SNOOZE.
REQ-011 In IDLE with set_en=1, each cycle with sel=1 SHALL toggle fld.
REQ-012 In IDLE with set_en=1, inc=1 SHALL increment the selected field; otherwise dec=1 SHALL decrement it; inc wins if both are high.
REQ-013 Hours SHALL wrap 23->0 and 0->23; minutes SHALL wrap 59->0 and 0->59; the unselected field SHALL be unchanged.
REQ-014 set_en, sel, inc and dec SHALL be ignored outside IDLE, and inc/dec SHALL be ignored when set_en=0.
REQ-015 IDLE with arm=1 SHALL go to ARMED on the next edge; arm has priority over edits in the same cycle.
REQ-016 ARMED with arm=1 SHALL go to IDLE.
REQ-017 ARMED with tick=1, hrs==alm_hrs, mins==alm_mins and sec==0 SHALL go to RINGING on the next edge (1-cycle latency).
REQ-018 A time match without tick SHALL NOT trigger RINGING.
REQ-019 In RINGING, a 6-bit ring counter SHALL count ticks from 0; when it reaches RING_TICKS-1 (59) with tick=1, the FSM SHALL return to ARMED.
REQ-020 RINGING priorities: arm -> IDLE; else stop -> ARMED; else snooze -> SNOOZE (only when SNOOZE_EN is defined and fewer than MAX_SNOOZE snoozes have been used).
REQ-021 In SNOOZE, a 9-bit counter SHALL count ticks; at SNOOZE_TICKS-1 (299) with tick=1, the FSM SHALL go to RINGING and the ring counter SHALL restart at 0.
REQ-022 In SNOOZE, arm SHALL go to IDLE and stop SHALL go to ARMED, with arm taking priority.
REQ-023 A 2-bit snooze-used count SHALL increment on each RINGING->SNOOZE transition and clear on any entry to ARMED or IDLE.
REQ-024 A snooze request with the count equal to MAX_SNOOZE (3) SHALL be ignored, and ringing SHALL continue.
REQ-025 ring and armed SHALL be registered outputs decoded from the state register and SHALL carry no combinational path from any input.
REQ-026 A stop or snooze input in IDLE or ARMED SHALL have no effect.

Reset
REQ-027 On rst the block SHALL set state=IDLE, alm_hrs=6, alm_mins=0, fld=0, armed=0, ring=0, and all counters to 0.
REQ-028 rst asserted mid-RINGING or mid-SNOOZE SHALL drop ring in the same asynchronous event, and the programmed alarm time SHALL be lost (returned to 06:00).

Configuration
REQ-029 The macro ALARM_SNOOZE_EN SHALL compile in the SNOOZE state, the snooze counter and the snooze-used logic.
REQ-030 Without ALARM_SNOOZE_EN, the snooze input SHALL be unused, SNOOZE SHALL be unreachable, and RINGING SHALL leave only via timeout, stop or arm.

Structure
REQ-031 The shared package watch_pkg SHALL hold the state enum and the constants HRS_MAX=23, MIN_MAX=59, RING_TICKS=60, SNOOZE_TICKS=300 and MAX_SNOOZE=3.
REQ-032 The wrap-around up/down field adjust SHALL be a single sub-module, mod_updown, instantiated twice (N=24 for hours, N=60 for minutes).

Verification
REQ-033 Edit wrap: with set_en=1 and fld=0, from 06:00, 7 cycles of dec -> alm_hrs=23; then sel, then 1 inc from mins=59 -> alm_mins=0.
REQ-034 Trigger: armed at 07:30, drive hrs=7, mins=30, sec=0 with tick=1 -> ring=1 on the next cycle; the same values with tick=0 -> ring stays 0.
REQ-035 Timeout: in RINGING, 60 ticks with no input -> ring=0 and state ARMED after the 60th tick; armed stays 1.
REQ-036 Snooze (ALARM_SNOOZE_EN defined): snooze in RINGING -> ring=0; after 300 ticks -> ring=1; the 4th snooze press -> ignored, ring stays 1.
REQ-037 Priority: stop and snooze in the same cycle in RINGING -> ARMED; arm and stop together -> IDLE with armed=0.
REQ-038 Reset: rst pulsed mid-SNOOZE -> state IDLE, alm_hrs=6, alm_mins=0, ring=0 and armed=0 immediately.
